// File: rtl/ahb_slave_mux.sv
// AHB-Lite slave-side response mux with decode-error and slave-timeout handling.
// Ports: HCLK/HRESET; HSEL/HTRANS address phase; HRDATAS/HREADYOUTS/HRESPS
// per-slave responses; ErrClr clears error status; HRDATA/HREADY/HRESP to the
// master; DSEL data-phase select; TimeoutFlag/TimeoutSlv/DecErrFlag/ErrCount
// error status.
module ahb_slave_mux #(
  parameter int NSLV    = 8,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NSLV-1:0]      HSEL,
  input  logic [1:0]           HTRANS,
  input  logic [NSLV*DW-1:0]   HRDATAS,
  input  logic [NSLV-1:0]      HREADYOUTS,
  input  logic [NSLV-1:0]      HRESPS,
  input  logic                 ErrClr,
  output logic [DW-1:0]        HRDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic [NSLV-1:0]      DSEL,
  output logic                 TimeoutFlag,
  output logic [((NSLV > 1) ? $clog2(NSLV) : 1)-1:0] TimeoutSlv,
  output logic                 DecErrFlag,
  output logic [7:0]           ErrCount
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SLV,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e          state_q, state_d;
  logic [NSLV-1:0] dsel_q, dsel_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            tflag_q, tflag_d;
  logic [SW-1:0]   tslv_q, tslv_d;
  logic            dflag_q, dflag_d;
  logic [7:0]      ecnt_q, ecnt_d;

  logic            active;
  logic            onehot;
  logic [DW-1:0]   mux_data;
  logic            sel_rdy;
  logic            sel_resp;
  logic [SW-1:0]   dsel_idx;
  logic [CW-1:0]   wait_inc;
  logic            timeout_hit;
  logic            dec_err;
  logic            to_err;

  // Address-phase qualification
  assign active = HTRANS[1];
  assign onehot = (HSEL != '0) &&
                  ((HSEL & (HSEL - NSLV'(1))) == '0);

  // One-hot AND-OR response mux; DSEL=0 gives all-zero data,
  // not-ready and OKAY.
  always_comb begin
    mux_data = '0;
    sel_rdy  = 1'b0;
    sel_resp = 1'b0;
    dsel_idx = '0;
    for (int i = 0; i < NSLV; i++) begin
      mux_data = mux_data |
                 (HRDATAS[i*DW +: DW] & {DW{dsel_q[i]}});
      sel_rdy  = sel_rdy  | (HREADYOUTS[i] & dsel_q[i]);
      sel_resp = sel_resp | (HRESPS[i] & dsel_q[i]);
      if (dsel_q[i]) dsel_idx = SW'(i);
    end
  end

  // The timeout fires on the wait cycle that brings the count up
  // to TIMEOUT, so a hung slave stalls for exactly TIMEOUT cycles.
  assign wait_inc    = wait_q + CW'(1);
  assign timeout_hit = (TIMEOUT > 0) &&
                       (wait_inc == CW'(TIMEOUT));

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Whenever HREADY is high the address phase
  // is sampled, independent of which state completed the transfer.
  always_comb begin
    state_d = state_q;
    dsel_d  = dsel_q;
    wait_d  = wait_q;
    dec_err = 1'b0;
    to_err  = 1'b0;
    if (HREADY) begin
      wait_d = '0;
      if (!active) begin
        state_d = S_IDLE;
        dsel_d  = '0;
      end else if (onehot) begin
        state_d = S_SLV;
        dsel_d  = HSEL;
      end else begin
        state_d = S_ERR1;
        dsel_d  = '0;
        dec_err = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_SLV: begin
          if (timeout_hit) begin
            state_d = S_ERR1;
            dsel_d  = '0;
            to_err  = 1'b1;
          end else if (TIMEOUT > 0) begin
            wait_d = wait_inc;
          end
        end
        S_ERR1:  state_d = S_ERR2;
        default: state_d = state_q;
      endcase
    end
  end

  // Output logic
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    unique case (state_q)
      S_IDLE: begin
        HREADY = 1'b1;
      end
      S_SLV: begin
        HREADY = sel_rdy;
        HRESP  = sel_resp;
        HRDATA = mux_data;
      end
      S_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      S_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        HREADY = 1'b1;
      end
    endcase
  end

  // Error status: a new error sets its flag even under ErrClr,
  // while ErrClr beats the counter increment.
  always_comb begin
    dflag_d = dflag_q;
    tflag_d = tflag_q;
    tslv_d  = tslv_q;
    ecnt_d  = ecnt_q;
    if (ErrClr) begin
      dflag_d = 1'b0;
      tflag_d = 1'b0;
      ecnt_d  = '0;
    end else if ((dec_err || to_err) && (ecnt_q != 8'hFF)) begin
      ecnt_d = ecnt_q + 8'd1;
    end
    if (dec_err) dflag_d = 1'b1;
    if (to_err) begin
      tflag_d = 1'b1;
      tslv_d  = dsel_idx;
    end
  end

  // Datapath and status registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_q  <= '0;
      wait_q  <= '0;
      tflag_q <= 1'b0;
      tslv_q  <= '0;
      dflag_q <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      dsel_q  <= dsel_d;
      wait_q  <= wait_d;
      tflag_q <= tflag_d;
      tslv_q  <= tslv_d;
      dflag_q <= dflag_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign DSEL        = dsel_q;
  assign TimeoutFlag = tflag_q;
  assign TimeoutSlv  = tslv_q;
  assign DecErrFlag  = dflag_q;
  assign ErrCount    = ecnt_q;

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Directed self-checking bench for ahb_slave_mux.
// Uses TIMEOUT=4 so the hung-slave path is short.
module tb_ahb_slave_mux;

  localparam int NSLV = 8;
  localparam int DW   = 64;
  localparam int TO   = 4;

  logic                HCLK = 1'b0;
  logic                HRESET = 1'b1;
  logic [NSLV-1:0]     HSEL = '0;
  logic [1:0]          HTRANS = 2'b00;
  logic [NSLV*DW-1:0]  HRDATAS;
  logic [NSLV-1:0]     HREADYOUTS = '1;
  logic [NSLV-1:0]     HRESPS = '0;
  logic                ErrClr = 1'b0;
  logic [DW-1:0]       HRDATA;
  logic                HREADY;
  logic                HRESP;
  logic [NSLV-1:0]     DSEL;
  logic                TimeoutFlag;
  logic [2:0]          TimeoutSlv;
  logic                DecErrFlag;
  logic [7:0]          ErrCount;

  logic [DW-1:0] sd [NSLV];

  int n_chk  = 0;
  int n_fail = 0;

  ahb_slave_mux #(
    .NSLV(NSLV),
    .DW(DW),
    .TIMEOUT(TO)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .HSEL(HSEL),
    .HTRANS(HTRANS),
    .HRDATAS(HRDATAS),
    .HREADYOUTS(HREADYOUTS),
    .HRESPS(HRESPS),
    .ErrClr(ErrClr),
    .HRDATA(HRDATA),
    .HREADY(HREADY),
    .HRESP(HRESP),
    .DSEL(DSEL),
    .TimeoutFlag(TimeoutFlag),
    .TimeoutSlv(TimeoutSlv),
    .DecErrFlag(DecErrFlag),
    .ErrCount(ErrCount)
  );

  always #5 HCLK = ~HCLK;

  always_comb begin
    HRDATAS = '0;
    for (int i = 0; i < NSLV; i++) HRDATAS[i*DW +: DW] = sd[i];
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    HTRANS = 2'b00;
    HSEL   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NSLV; i++) sd[i] = 64'h1100 + 64'(i);
    sd[2] = 64'hA5;
    sd[5] = 64'hDEAD;

    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hready", 64'(HREADY), 64'd1);
    chk("rst_hresp", 64'(HRESP), 64'd0);
    chk("rst_hrdata", HRDATA, 64'd0);
    chk("rst_dsel", 64'(DSEL), 64'd0);
    chk("rst_flags", {61'd0, TimeoutFlag, DecErrFlag, 1'b0}, 64'd0);
    chk("rst_tslv", 64'(TimeoutSlv), 64'd0);
    chk("rst_ecnt", 64'(ErrCount), 64'd0);
    HRESET = 1'b0;

    // Slave 2 with two wait states
    HREADYOUTS[2] = 1'b0;
    HTRANS = 2'b10;
    HSEL   = 8'h04;
    tick();
    idle_bus();
    #1;
    chk("s2_w1_hready", 64'(HREADY), 64'd0);
    chk("s2_dsel", 64'(DSEL), 64'h04);
    tick();
    chk("s2_w2_hready", 64'(HREADY), 64'd0);
    tick();
    HREADYOUTS[2] = 1'b1;
    #1;
    chk("s2_rdy_hready", 64'(HREADY), 64'd1);
    chk("s2_rdy_hrdata", HRDATA, 64'hA5);
    chk("s2_rdy_hresp", 64'(HRESP), 64'd0);
    tick();
    chk("s2_end_dsel", 64'(DSEL), 64'd0);
    chk("s2_end_hrdata", HRDATA, 64'd0);

    // IDLE and BUSY with no select
    HTRANS = 2'b00;
    tick();
    chk("idle_hready", 64'(HREADY), 64'd1);
    HTRANS = 2'b01;
    tick();
    chk("busy_hready", 64'(HREADY), 64'd1);
    chk("busy_hresp", 64'(HRESP), 64'd0);
    chk("busy_ecnt", 64'(ErrCount), 64'd0);
    chk("busy_dec", 64'(DecErrFlag), 64'd0);
    idle_bus();

    // Ready on the same cycle the timeout would fire
    HREADYOUTS[3] = 1'b0;
    HTRANS = 2'b10;
    HSEL   = 8'h08;
    tick();
    idle_bus();
    repeat (3) tick();
    HREADYOUTS[3] = 1'b1;
    #1;
    chk("race_hready", 64'(HREADY), 64'd1);
    chk("race_hresp", 64'(HRESP), 64'd0);
    chk("race_hrdata", HRDATA, 64'h1103);
    tick();
    chk("race_tflag", 64'(TimeoutFlag), 64'd0);
    chk("race_ecnt", 64'(ErrCount), 64'd0);
    chk("race_hresp2", 64'(HRESP), 64'd0);

    // Unmapped NONSEQ
    HTRANS = 2'b10;
    HSEL   = '0;
    tick();
    idle_bus();
    #1;
    chk("dec0_e1_hresp", 64'(HRESP), 64'd1);
    chk("dec0_e1_hready", 64'(HREADY), 64'd0);
    chk("dec0_flag", 64'(DecErrFlag), 64'd1);
    chk("dec0_ecnt", 64'(ErrCount), 64'd1);
    tick();
    chk("dec0_e2_hresp", 64'(HRESP), 64'd1);
    chk("dec0_e2_hready", 64'(HREADY), 64'd1);
    tick();
    chk("dec0_end_hresp", 64'(HRESP), 64'd0);

    // ErrClr while idle
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    #1;
    chk("clr_dec", 64'(DecErrFlag), 64'd0);
    chk("clr_ecnt", 64'(ErrCount), 64'd0);

    // Multi-hot select
    HTRANS = 2'b10;
    HSEL   = 8'h03;
    tick();
    idle_bus();
    #1;
    chk("mh_e1_hresp", 64'(HRESP), 64'd1);
    chk("mh_e1_hready", 64'(HREADY), 64'd0);
    chk("mh_dsel", 64'(DSEL), 64'd0);
    chk("mh_flag", 64'(DecErrFlag), 64'd1);
    chk("mh_ecnt", 64'(ErrCount), 64'd1);
    tick();
    chk("mh_e2_hresp", 64'(HRESP), 64'd1);
    chk("mh_e2_hready", 64'(HREADY), 64'd1);
    tick();

    // Slave-originated ERROR passes through
    HREADYOUTS[1] = 1'b0;
    HRESPS[1]     = 1'b1;
    HTRANS = 2'b10;
    HSEL   = 8'h02;
    tick();
    idle_bus();
    #1;
    chk("serr_c1_hresp", 64'(HRESP), 64'd1);
    chk("serr_c1_hready", 64'(HREADY), 64'd0);
    tick();
    HREADYOUTS[1] = 1'b1;
    #1;
    chk("serr_c2_hresp", 64'(HRESP), 64'd1);
    chk("serr_c2_hready", 64'(HREADY), 64'd1);
    tick();
    HRESPS[1] = 1'b0;
    #1;
    chk("serr_ecnt", 64'(ErrCount), 64'd1);

    // Hung slave 5
    HREADYOUTS[5] = 1'b0;
    HTRANS = 2'b10;
    HSEL   = 8'h20;
    tick();
    idle_bus();
    for (int c = 0; c < TO; c++) begin
      #1;
      chk("to_wait_hready", 64'(HREADY), 64'd0);
      chk("to_wait_dsel", 64'(DSEL), 64'h20);
      tick();
    end
    chk("to_e1_hresp", 64'(HRESP), 64'd1);
    chk("to_e1_hready", 64'(HREADY), 64'd0);
    chk("to_dsel", 64'(DSEL), 64'd0);
    chk("to_flag", 64'(TimeoutFlag), 64'd1);
    chk("to_slv", 64'(TimeoutSlv), 64'd5);
    chk("to_ecnt", 64'(ErrCount), 64'd2);
    HREADYOUTS[5] = 1'b1;
    #1;
    chk("to_late_hready", 64'(HREADY), 64'd0);
    tick();
    chk("to_e2_hresp", 64'(HRESP), 64'd1);
    chk("to_e2_hready", 64'(HREADY), 64'd1);
    tick();
    chk("to_end_hresp", 64'(HRESP), 64'd0);
    chk("to_end_hrdata", HRDATA, 64'd0);

    // Saturation and clear-on-entry
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    #1;
    chk("sat_pre_tflag", 64'(TimeoutFlag), 64'd0);
    chk("sat_pre_ecnt", 64'(ErrCount), 64'd0);
    HTRANS = 2'b10;
    HSEL   = '0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 253) chk("sat_254", 64'(ErrCount), 64'd254);
      if (i < 255) tick();
    end
    chk("sat_ecnt", 64'(ErrCount), 64'd255);
    chk("sat_e1_hready", 64'(HREADY), 64'd0);
    tick();
    chk("sat_e2_hresp", 64'(HRESP), 64'd1);
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    idle_bus();
    #1;
    chk("clrent_ecnt", 64'(ErrCount), 64'd0);
    chk("clrent_dec", 64'(DecErrFlag), 64'd1);
    chk("clrent_hready", 64'(HREADY), 64'd0);
    repeat (2) tick();

    // Reset during SLV wait
    HREADYOUTS[2] = 1'b0;
    HTRANS = 2'b10;
    HSEL   = 8'h04;
    tick();
    idle_bus();
    #1;
    chk("rmid_wait", 64'(HREADY), 64'd0);
    HRESET = 1'b1;
    #1;
    chk("rmid_hready", 64'(HREADY), 64'd1);
    chk("rmid_hresp", 64'(HRESP), 64'd0);
    chk("rmid_hrdata", HRDATA, 64'd0);
    chk("rmid_dsel", 64'(DSEL), 64'd0);
    chk("rmid_dec", 64'(DecErrFlag), 64'd0);
    chk("rmid_ecnt", 64'(ErrCount), 64'd0);
    tick();
    HRESET = 1'b0;
    HREADYOUTS[2] = 1'b1;
    HTRANS = 2'b10;
    HSEL   = 8'h04;
    tick();
    idle_bus();
    #1;
    chk("rpost_dsel", 64'(DSEL), 64'h04);
    chk("rpost_hready", 64'(HREADY), 64'd1);
    chk("rpost_hrdata", HRDATA, 64'hA5);
    chk("rpost_hresp", 64'(HRESP), 64'd0);
    tick();
    chk("rpost_end", 64'(DSEL), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
